// File: rtl/axi_lite_cfg_sequencer.sv
// AXI4-Lite write-only configuration sequencer.
// On START, walks a command table one entry at a time and issues one AXI-Lite write
// per entry to C_BASE_ADDR + offset. It keeps a single write outstanding and checks
// every BRESP. DONE and ERROR are sticky until the next accepted START.
module axi_lite_cfg_sequencer #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_NUM_COMMANDS     = 8,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h8800_0000,
    localparam int CW = (C_NUM_COMMANDS > 1) ? $clog2(C_NUM_COMMANDS) : 1
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic                              START,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              ERROR,
    output logic [CW-1:0]                     ERR_IDX,
    output logic [CW-1:0]                     CMD_IDX,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_OFFSET,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_DATA,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY
);

    localparam logic [CW-1:0] LAST_IDX = CW'(C_NUM_COMMANDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_RESP,
        S_FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic aw_ok;
    logic w_ok;
    logic issue_done;
    logic b_err;
    logic last_cmd;

    // A channel counts as finished once its valid has dropped, or when it handshakes this cycle.
    assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs       = M_AXI_BVALID & M_AXI_BREADY;
    assign aw_ok      = ~M_AXI_AWVALID | aw_hs;
    assign w_ok       = ~M_AXI_WVALID | w_hs;
    assign issue_done = aw_ok & w_ok;
    assign b_err      = (M_AXI_BRESP != 2'b00);
    assign last_cmd   = (CMD_IDX == LAST_IDX);

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_WSTRB  = '1;

    // State register; reset aborts any run in flight.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode for the walk through the table.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (issue_done) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (b_hs) begin
                    if (b_err || last_cmd) begin
                        state_next = S_FINISH;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Status flags, table index and AXI channel registers, updated per state.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            BUSY          <= 1'b0;
            DONE          <= 1'b0;
            ERROR         <= 1'b0;
            ERR_IDX       <= '0;
            CMD_IDX       <= '0;
            M_AXI_AWADDR  <= '0;
            M_AXI_WDATA   <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        CMD_IDX <= '0;
                        DONE    <= 1'b0;
                        ERROR   <= 1'b0;
                        BUSY    <= 1'b1;
                    end
                end
                S_FETCH: begin
                    // The sum is truncated to the address width, so large offsets wrap.
                    M_AXI_AWADDR  <= C_BASE_ADDR + CMD_OFFSET;
                    M_AXI_WDATA   <= CMD_DATA;
                    M_AXI_AWVALID <= 1'b1;
                    M_AXI_WVALID  <= 1'b1;
                end
                S_ISSUE: begin
                    if (aw_hs) begin
                        M_AXI_AWVALID <= 1'b0;
                    end
                    if (w_hs) begin
                        M_AXI_WVALID <= 1'b0;
                    end
                    if (issue_done) begin
                        M_AXI_BREADY <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (b_hs) begin
                        M_AXI_BREADY <= 1'b0;
                        if (b_err) begin
                            ERROR   <= 1'b1;
                            ERR_IDX <= CMD_IDX;
                        end else if (!last_cmd) begin
                            CMD_IDX <= CMD_IDX + CW'(1);
                        end
                    end
                end
                S_FINISH: begin
                    DONE <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// Directed testbench for axi_lite_cfg_sequencer: an 8-entry instance driven by a
// configurable AXI-Lite slave model, plus a 1-entry instance for the address-wrap case.
`timescale 1ns/1ps
module tb_axi_lite_cfg_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    // Main instance, 8 commands
    logic        busy, done, error;
    logic [2:0]  err_idx, cmd_idx;
    logic [31:0] cmd_offset, cmd_data;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic        awvalid, wvalid, bready;
    logic        awready = 1'b0;
    logic        wready = 1'b0;
    logic        bvalid = 1'b0;
    logic [1:0]  bresp = 2'b00;

    assign cmd_offset = {27'd0, cmd_idx, 2'b00};
    assign cmd_data   = 32'hCAFE_0000 | {29'd0, cmd_idx};

    axi_lite_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_NUM_COMMANDS(8),
        .C_BASE_ADDR(32'h8800_0000)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n), .START(start),
        .BUSY(busy), .DONE(done), .ERROR(error),
        .ERR_IDX(err_idx), .CMD_IDX(cmd_idx),
        .CMD_OFFSET(cmd_offset), .CMD_DATA(cmd_data),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
        .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready)
    );

    // Second instance, single command whose offset wraps the address
    logic        start2 = 1'b0;
    logic        busy2, done2, error2;
    logic [0:0]  err_idx2, cmd_idx2;
    logic [31:0] awaddr2, wdata2;
    logic [2:0]  awprot2;
    logic [3:0]  wstrb2;
    logic        awvalid2, wvalid2, bready2;
    logic        bvalid2 = 1'b0;

    axi_lite_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_NUM_COMMANDS(1),
        .C_BASE_ADDR(32'h8800_0000)
    ) dut1 (
        .ACLK(clk), .ARESETN(rst_n), .START(start2),
        .BUSY(busy2), .DONE(done2), .ERROR(error2),
        .ERR_IDX(err_idx2), .CMD_IDX(cmd_idx2),
        .CMD_OFFSET(32'h7800_0000), .CMD_DATA(32'h1234_5678),
        .M_AXI_AWADDR(awaddr2), .M_AXI_AWPROT(awprot2),
        .M_AXI_AWVALID(awvalid2), .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(wdata2), .M_AXI_WSTRB(wstrb2),
        .M_AXI_WVALID(wvalid2), .M_AXI_WREADY(1'b1),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(bvalid2), .M_AXI_BREADY(bready2)
    );

    // Slave model configuration (written only by the main sequence)
    int         aw_delay = 0;
    int         w_delay = 0;
    int         err_at = -1;
    logic [1:0] err_resp = 2'b10;

    // Slave model state and logs (written only by the slave model)
    int          aw_wc = 0, w_wc = 0;
    int          aw_total = 0, w_total = 0, b_total = 0;
    bit          b_acc = 1'b0, aw_wait = 1'b0, w_wait = 1'b0;
    logic [31:0] aw_hold = '0, w_hold = '0;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];
    int          stab_err = 0, order_err = 0;

    // Slave for the main instance: delayed readies, B one cycle after both accepts
    always @(negedge clk) begin
        if (!rst_n) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            b_acc = 1'b0; aw_wait = 1'b0; w_wait = 1'b0; aw_wc = 0; w_wc = 0;
            aw_total = b_total; w_total = b_total;
        end else begin
            if (aw_wait && (!awvalid || awaddr !== aw_hold)) stab_err++;
            if (w_wait && (!wvalid || wdata !== w_hold)) stab_err++;
            if (bready && (awvalid || wvalid)) order_err++;
            if (bvalid && b_acc) begin
                bvalid = 1'b0; b_acc = 1'b0;
            end
            if (!bvalid && b_total < aw_total && b_total < w_total) begin
                bvalid = 1'b1;
                bresp = (b_total == err_at) ? err_resp : 2'b00;
                b_total++;
            end
            if (bvalid && bready) b_acc = 1'b1;
            if (awvalid) begin
                awready = (aw_wc >= aw_delay); aw_wc++;
            end else begin
                awready = 1'b0; aw_wc = 0;
            end
            if (wvalid) begin
                wready = (w_wc >= w_delay); w_wc++;
            end else begin
                wready = 1'b0; w_wc = 0;
            end
            aw_wait = awvalid && !awready; aw_hold = awaddr;
            w_wait  = wvalid && !wready;   w_hold  = wdata;
            if (awvalid && awready) begin
                aw_q.push_back(awaddr); aw_total++;
            end
            if (wvalid && wready) begin
                w_q.push_back(wdata); w_total++;
            end
        end
    end

    // Slave for the single-command instance (readies tied high)
    int          aw2_cnt = 0;
    logic [31:0] aw2_addr = 32'hFFFF_FFFF;
    bit          b2_acc = 1'b0, b2_pend = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            bvalid2 = 1'b0; b2_acc = 1'b0; b2_pend = 1'b0;
        end else begin
            if (bvalid2 && b2_acc) begin
                bvalid2 = 1'b0; b2_acc = 1'b0;
            end
            if (b2_pend) begin
                bvalid2 = 1'b1; b2_pend = 1'b0;
            end
            if (bvalid2 && bready2) b2_acc = 1'b1;
            if (awvalid2) begin
                aw2_cnt++; aw2_addr = awaddr2;
            end
            if (wvalid2) b2_pend = 1'b1;
        end
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic s_busy0, s_done0, s_err0, s_awv0, s_awv1, s_awv2, s_wv2, s_br2;

    // Pulse START, then step until DONE or budget; optional START pokes while running.
    task automatic run_table(input bit poke, output int cyc);
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        s_busy0 = busy; s_done0 = done; s_err0 = error; s_awv0 = awvalid;
        while (done !== 1'b1 && cyc < 300) begin
            if (poke && (cyc == 4 || cyc == 12 || cyc == 24)) start = 1'b1;
            step();
            start = 1'b0;
            cyc++;
            if (cyc == 1) s_awv1 = awvalid;
            if (cyc == 2) begin
                s_awv2 = awvalid; s_wv2 = wvalid; s_br2 = bready;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int base;
        int wbase;

        // Reset state
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_bready", bready, 0);
        check("rst_cmd_idx", cmd_idx, 0);
        check("rst_err_idx", err_idx, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_wdata", wdata, 0);
        check("const_awprot", awprot, 3'b000);
        check("const_wstrb", wstrb, 4'hF);
        rst_n = 1'b1;
        step();

        // Test 1: ready-high slave, full table in order
        base = aw_q.size(); wbase = w_q.size();
        run_table(1'b0, cyc);
        check("t1_busy_c1", s_busy0, 1);
        check("t1_awvalid_c1", s_awv0, 0);
        check("t1_awvalid_c2", s_awv1, 1);
        check("t1_done", done, 1);
        check("t1_error", error, 0);
        check("t1_busy_at_done", busy, 0);
        check("t1_done_cycle", cyc, 25);
        check("t1_aw_count", aw_q.size() - base, 8);
        check("t1_w_count", w_q.size() - wbase, 8);
        for (int i = 0; i < 8; i++) begin
            if (aw_q.size() > base + i) check("t1_awaddr", aw_q[base + i], 32'h8800_0000 + 32'(4 * i));
            if (w_q.size() > wbase + i) check("t1_wdata", w_q[wbase + i], 32'hCAFE_0000 + 32'(i));
        end
        check("t1_cmd_idx_last", cmd_idx, 7);

        // Test 2a: AWREADY delayed 3 cycles, WREADY immediate
        aw_delay = 3; w_delay = 0;
        base = aw_q.size();
        run_table(1'b0, cyc);
        check("t2a_awvalid_held", s_awv2, 1);
        check("t2a_wvalid_dropped", s_wv2, 0);
        check("t2a_bready_early", s_br2, 0);
        check("t2a_done", done, 1);
        check("t2a_error", error, 0);
        check("t2a_done_cycle", cyc, 49);
        check("t2a_aw_count", aw_q.size() - base, 8);
        check("t2a_stability", stab_err, 0);
        check("t2a_bready_order", order_err, 0);

        // Test 2b: reversed delays
        aw_delay = 0; w_delay = 3;
        base = aw_q.size();
        run_table(1'b0, cyc);
        check("t2b_awvalid_dropped", s_awv2, 0);
        check("t2b_wvalid_held", s_wv2, 1);
        check("t2b_bready_early", s_br2, 0);
        check("t2b_done_cycle", cyc, 49);
        check("t2b_aw_count", aw_q.size() - base, 8);
        check("t2b_last_addr", aw_q[aw_q.size() - 1], 32'h8800_001C);
        check("t2b_stability", stab_err, 0);
        check("t2b_bready_order", order_err, 0);
        aw_delay = 0; w_delay = 0;

        // Test 3: SLVERR on command 3 stops the run
        err_at = b_total + 3;
        base = aw_q.size();
        run_table(1'b0, cyc);
        err_at = -1;
        check("t3_error", error, 1);
        check("t3_err_idx", err_idx, 3);
        check("t3_done", done, 1);
        check("t3_busy", busy, 0);
        check("t3_done_cycle", cyc, 13);
        check("t3_aw_count", aw_q.size() - base, 4);
        check("t3_cmd_idx", cmd_idx, 3);

        // Test 4: START pokes while busy and in FINISH are ignored; restart clears flags
        base = aw_q.size();
        run_table(1'b1, cyc);
        check("t4_done_cleared", s_done0, 0);
        check("t4_error_cleared", s_err0, 0);
        check("t4_done", done, 1);
        check("t4_error", error, 0);
        check("t4_done_cycle", cyc, 25);
        repeat (4) step();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_awvalid", awvalid, 0);
        check("t4_aw_count", aw_q.size() - base, 8);
        base = aw_q.size();
        run_table(1'b0, cyc);
        check("t4_rerun_done", done, 1);
        check("t4_rerun_count", aw_q.size() - base, 8);
        check("t4_rerun_first", aw_q[base], 32'h8800_0000);
        check("t4_rerun_cycle", cyc, 25);

        // Test 5: asynchronous reset during ISSUE of command 2
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        check("t5_pre_awvalid", awvalid, 1);
        check("t5_pre_cmd_idx", cmd_idx, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_awvalid", awvalid, 0);
        check("t5_rst_wvalid", wvalid, 0);
        check("t5_rst_bready", bready, 0);
        check("t5_rst_cmd_idx", cmd_idx, 0);
        check("t5_rst_awaddr", awaddr, 0);
        check("t5_rst_wdata", wdata, 0);
        check("t5_rst_err_idx", err_idx, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("t5_idle_awvalid", awvalid, 0);
        base = aw_q.size();
        run_table(1'b0, cyc);
        check("t5_done", done, 1);
        check("t5_count", aw_q.size() - base, 8);
        check("t5_first_addr", aw_q[base], 32'h8800_0000);
        check("t5_done_cycle", cyc, 25);

        // Test 6: single-entry table, address wraps to zero
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 50 && done2 !== 1'b1; i++) step();
        check("t6_done", done2, 1);
        check("t6_error", error2, 0);
        check("t6_busy", busy2, 0);
        check("t6_aw_count", aw2_cnt, 1);
        check("t6_awaddr_wrap", aw2_addr, 32'h0000_0000);
        check("t6_cmd_idx", cmd_idx2, 0);

        check("final_stability", stab_err, 0);
        check("final_bready_order", order_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
